dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sequences data-memory transactions for the RV32 core.
- Takes MemRead/MemWrite from the main decoder plus address, store data and funct3, and drives a variable-latency req/ack memory port.
- Stalls the pipeline until the access completes, and returns sign- or zero-extended load data.
- Performs byte-lane steering and misalignment/illegal-size checks, and has a timeout watchdog.

Parameters:
- ADDR_W, 32, width of the byte address.
- TIMEOUT, 16, maximum cycles in REQ without mem_ack_i before abort; 0 disables the watchdog.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- mem_read_i  in  1  MemRead from decoder
- mem_write_i  in  1  MemWrite from decoder
- funct3_i  in  3  load/store size code
- addr_i  in  ADDR_W  byte address from ALU
- wdata_i  in  32  store data (rs2)
- stall_o  out  1  holds PC and pipeline registers while high
- rdata_o  out  32  extended load result
- rvalid_o  out  1  one-cycle pulse; load or store completed
- err_o  out  1  one-cycle pulse; misaligned, illegal funct3, both read and write, or timeout
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-replicated store data
- mem_rdata_i  in  32  read word
- mem_ack_i  in  1  memory completes the request this cycle

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0, including rdata_o, mem_addr_o, mem_wdata_o and mem_be_o.
  - The timeout counter is 0.
  - mem_req_o drops immediately, even mid-transaction.
- States: IDLE, REQ, RESP.
- IDLE, neither mem_read_i nor mem_write_i: no action, stall_o=0.
- IDLE, an access is requested: validity checks, in order:
  - Both mem_read_i and mem_write_i set: error.
  - funct3 is not in {000,001,010,100,101} for a load, or not in {000,001,010} for a store: error.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0: error.
- On error:
  - err_o=1 for that cycle, stall_o=0, no memory request, remain in IDLE.
- On a valid access:
  - stall_o=1 combinationally in the same cycle.
  - Register we, word address, byte enables, store data, funct3 and addr[1:0].
  - Go to REQ.
- Byte enables and store data:
  - sb: be=4'b0001<<addr[1:0], wdata={4{wdata_i[7:0]}}.
  - sh: be=4'b0011<<addr[1:0], wdata={2{wdata_i[15:0]}}.
  - sw: be=4'b1111, wdata=wdata_i.
  - Loads: be=4'b1111.
- REQ:
  - mem_req_o=1 and stall_o=1.
  - All mem_* outputs are held stable until mem_ack_i.
  - The counter increments each REQ cycle.
  - mem_ack_i=1: capture and extract mem_rdata_i for loads, go to RESP.
  - Otherwise, if TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ack: err_o=1, mem_req_o=0 next cycle, go to IDLE, stall_o=0 next cycle.
  - An ack on the same cycle as the counter expiry wins; no error is raised.
- Load extraction, by funct3 and the stored addr[1:0]:
  - lb/lbu: byte at lane addr[1:0], sign- or zero-extended.
  - lh/lhu: half at addr[1], sign- or zero-extended.
  - lw: full word.
- RESP:
  - stall_o=0, rvalid_o=1 for exactly one cycle.
  - rdata_o holds the extracted value (stores leave rdata_o unchanged).
  - mem_read_i/mem_write_i are ignored this cycle, because the same instruction is still presented.
  - Always return to IDLE.
- rdata_o holds its last load value until the next load completes.
- Latency: minimum 3 cycles (IDLE detect, REQ with ack, RESP); each REQ cycle without ack adds one.
- mem_ack_i outside REQ is ignored.

Test Plan:
- lw at addr 0x100; ack on the 1st REQ cycle, mem_rdata_i=0xDEADBEEF -> stall_o high for 2 cycles; mem_addr_o=0x100, be=1111; RESP rvalid_o=1, rdata_o=0xDEADBEEF.
- lb at 0x103 with rdata 0x80112233 -> rdata_o=0xFFFFFF80. lbu at the same address -> 0x00000080. lhu at 0x102 -> 0x00008011.
- sh at 0x102, wdata_i=0x1234ABCD, ack delayed 3 cycles -> mem_we_o=1, be=1100, mem_wdata_o=0xABCDABCD held stable; stall_o high 5 cycles; rvalid_o pulse.
- lw at 0x101 -> err_o=1 the same cycle, stall_o=0, mem_req_o never asserts. mem_read_i=mem_write_i=1 -> err_o. Load with funct3=011 -> err_o.
- TIMEOUT=16, no ack -> mem_req_o high exactly 16 cycles, err_o pulse on the 16th, then IDLE with stall_o=0.
- rst_n low in the 2nd REQ cycle -> mem_req_o and stall_o go 0 immediately. After release, a new lw completes normally in 3 cycles.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the RV32 core.
// Validates load/store requests, steers byte lanes onto a req/ack memory
// port, stalls the pipeline while the access is in flight, extends load
// data, and aborts requests that never get acknowledged.
module dmem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              rvalid_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ack_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_rdata;

    logic              w_access;
    logic              w_f3Ok;
    logic              w_aligned;
    logic              w_legal;
    logic              w_start;
    logic              w_expire;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_shift;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;

    // Request decode: gated by reset so every output reads 0 while reset is held
    assign w_access = (mem_read_i | mem_write_i) & rst_n;
    assign w_legal  = ~(mem_read_i & mem_write_i) & w_f3Ok & w_aligned;
    assign w_start  = (r_state == S_IDLE) & w_access & w_legal;
    assign w_expire = (r_state == S_REQ) & ~mem_ack_i & (TIMEOUT != 0) & (r_cnt == LAST_CNT);

    // Size legality, alignment, and byte-lane steering of the incoming request
    always_comb begin
        w_f3Ok    = 1'b0;
        w_aligned = 1'b1;
        w_be      = 4'b1111;
        w_wdata   = wdata_i;
        case (funct3_i)
            3'b000, 3'b001, 3'b010: w_f3Ok = 1'b1;
            3'b100, 3'b101:         w_f3Ok = ~mem_write_i;
            default:                w_f3Ok = 1'b0;
        endcase
        case (funct3_i[1:0])
            2'b01:   w_aligned = ~addr_i[0];
            2'b10:   w_aligned = (addr_i[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
        if (mem_write_i) begin
            case (funct3_i[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << addr_i[1:0];
                    w_wdata = {4{wdata_i[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << addr_i[1:0];
                    w_wdata = {2{wdata_i[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = wdata_i;
                end
            endcase
        end
    end

    // Load extraction from the returned word using the captured size and offset
    always_comb begin
        w_shift = mem_rdata_i >> {r_off, 3'b000};
        w_byte  = w_shift[7:0];
        w_half  = r_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = mem_rdata_i;
        endcase
    end

    // Next-state logic: an ack always beats a simultaneous watchdog expiry
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_REQ;
            S_REQ: begin
                if (mem_ack_i)     w_next = S_RESP;
                else if (w_expire) w_next = S_IDLE;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Transaction capture on a valid request, watchdog counter, and load result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_be     <= 4'd0;
            r_wdata  <= 32'd0;
            r_funct3 <= 3'd0;
            r_off    <= 2'd0;
            r_cnt    <= '0;
            r_rdata  <= 32'd0;
        end else begin
            if (w_start) begin
                r_we     <= mem_write_i;
                r_addr   <= {addr_i[ADDR_W-1:2], 2'b00};
                r_be     <= w_be;
                r_wdata  <= w_wdata;
                r_funct3 <= funct3_i;
                r_off    <= addr_i[1:0];
            end
            if (r_state == S_REQ) r_cnt <= r_cnt + 1'b1;
            else                  r_cnt <= '0;
            if ((r_state == S_REQ) && mem_ack_i && !r_we) r_rdata <= w_load;
        end
    end

    // Outputs: memory port is driven only while a request is outstanding
    assign stall_o     = w_start | (r_state == S_REQ);
    assign err_o       = ((r_state == S_IDLE) & w_access & ~w_legal) | w_expire;
    assign rvalid_o    = (r_state == S_RESP);
    assign mem_req_o   = (r_state == S_REQ);
    assign mem_we_o    = mem_req_o & r_we;
    assign mem_addr_o  = mem_req_o ? r_addr : '0;
    assign mem_be_o    = mem_req_o ? r_be : 4'd0;
    assign mem_wdata_o = mem_req_o ? r_wdata : 32'd0;
    assign rdata_o     = r_rdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus a
// randomized transaction stream, all checked against an arithmetic model.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, rvalid_o, err_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    int          nVectors = 0;
    int          nMiscompares = 0;
    logic [31:0] lastLoad = 32'd0;

    dmem_access_ctrl #(.ADDR_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    // Free-running core clock
    always #5 clk = ~clk;

    // Reference model: legality of a request
    function automatic bit m_legal(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
        int unsigned n;
        if (rd && wr) return 1'b0;
        if (rd && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1'b0;
        if (wr && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)) return 1'b0;
        n = 1 << f3[1:0];
        return (a % n) == 0;
    endfunction

    // Reference model: byte enables
    function automatic logic [3:0] m_be(input bit wr, input logic [2:0] f3, input logic [31:0] a);
        int unsigned n;
        if (!wr) return 4'hF;
        n = 1 << f3[1:0];
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    // Reference model: store data replicated across every lane
    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int unsigned n;
        n = 1 << f3[1:0];
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    // Reference model: extended load value
    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
        int unsigned off, n;
        longint v;
        off = a % 4;
        n = 1 << f3[1:0];
        v = (longint'(word) >> (8 * off)) % (longint'(1) << (8 * n));
        if (f3[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // Presents one instruction's memory fields to the DUT
    task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
        mem_read_i  = rd;
        mem_write_i = wr;
        funct3_i    = f3;
        addr_i      = a;
        wdata_i     = wd;
    endtask

    // One complete access, called just after a rising edge with the DUT idle
    task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rword, input int delay,
                              input string name);
        bit          acc, legal;
        logic [3:0]  expBe;
        logic [31:0] expWd;
        acc   = rd || wr;
        legal = m_legal(rd, wr, f3, a);
        expBe = m_be(wr, f3, a);
        expWd = m_wdata(f3, wd);
        applyStimulus(rd, wr, f3, a, wd);
        @(negedge clk);
        nVectors++;
        if ({stall_o, err_o, mem_req_o, rvalid_o} !== {acc && legal, acc && !legal, 1'b0, 1'b0}) begin
            nMiscompares++;
            $display("[TB] FAIL %s_issue: got stall/err/req/rvalid=%b want %b", name,
                     {stall_o, err_o, mem_req_o, rvalid_o}, {acc && legal, acc && !legal, 2'b00});
        end
        @(posedge clk); #1;
        if (!(acc && legal)) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            @(negedge clk);
            nVectors++;
            if ({mem_req_o, stall_o, err_o} !== 3'b000) begin
                nMiscompares++;
                $display("[TB] FAIL %s_noreq: got req/stall/err=%b want 000", name, {mem_req_o, stall_o, err_o});
            end
            @(posedge clk); #1;
            return;
        end
        for (int k = 0; k <= delay; k++) begin
            mem_ack_i   = (k == delay);
            mem_rdata_i = (k == delay) ? rword : $urandom;
            @(negedge clk);
            nVectors++;
            if ({mem_req_o, stall_o, err_o, rvalid_o, mem_we_o, mem_addr_o, mem_be_o} !==
                {4'b1100, wr, a & 32'hFFFF_FFFC, expBe}) begin
                nMiscompares++;
                $display("[TB] FAIL %s_req%0d: got req/stall/err/rv/we=%b addr=%h be=%b want %b addr=%h be=%b",
                         name, k, {mem_req_o, stall_o, err_o, rvalid_o, mem_we_o}, mem_addr_o, mem_be_o,
                         {4'b1100, wr}, a & 32'hFFFF_FFFC, expBe);
            end
            if (wr) begin
                nVectors++;
                if (mem_wdata_o !== expWd) begin
                    nMiscompares++;
                    $display("[TB] FAIL %s_wdata%0d: got %h want %h", name, k, mem_wdata_o, expWd);
                end
            end
            @(posedge clk); #1;
        end
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
        if (rd) lastLoad = m_load(f3, a, rword);
        @(negedge clk);
        nVectors++;
        if ({rvalid_o, stall_o, err_o, mem_req_o} !== 4'b1000 || rdata_o !== lastLoad) begin
            nMiscompares++;
            $display("[TB] FAIL %s_resp: got rv/stall/err/req=%b rdata=%h want 1000 rdata=%h",
                     name, {rvalid_o, stall_o, err_o, mem_req_o}, rdata_o, lastLoad);
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    // Everything reads zero while reset is held
    task automatic test_reset();
        nVectors++;
        if ({stall_o, rvalid_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, rdata_o} !== '0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_outputs: got ctrl=%b addr=%h be=%b wd=%h rd=%h want all zero",
                     {stall_o, rvalid_o, err_o, mem_req_o, mem_we_o}, mem_addr_o, mem_be_o, mem_wdata_o, rdata_o);
        end
    endtask

    // Word load and sign/zero-extended sub-word loads
    task automatic test_loads();
        run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, "lw");
        run_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, "lb");
        run_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1, "lbu");
        run_access(1, 0, 3'b101, 32'h102, 32'h0, 32'h80112233, 0, "lhu");
        run_access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80112233, 2, "lh");
    endtask

    // Stores with a slow memory; rdata_o must keep the previous load value
    task automatic test_stores();
        run_access(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 3, "sh");
        run_access(0, 1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 1, "sb");
        run_access(0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 0, "sw");
    endtask

    // Illegal requests raise err_o and never touch memory
    task automatic test_errors();
        run_access(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, "lw_misaligned");
        run_access(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, "rd_and_wr");
        run_access(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, "ld_f3_011");
        run_access(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, "st_f3_100");
        run_access(0, 1, 3'b001, 32'h103, 32'h0, 32'h0, 0, "sh_misaligned");
        run_access(0, 0, 3'b010, 32'h100, 32'h0, 32'h0, 0, "no_access");
    endtask

    // Ack on the last allowed REQ cycle wins over the watchdog
    task automatic test_ack_at_expiry();
        run_access(1, 0, 3'b010, 32'h40, 32'h0, 32'h13572468, 15, "ack_at_expiry");
    endtask

    // Watchdog aborts after exactly TIMEOUT request cycles
    task automatic test_timeout();
        int reqCycles = 0;
        applyStimulus(1, 0, 3'b010, 32'h200, 32'h0);
        mem_ack_i = 1'b0;
        @(posedge clk); #1;
        applyStimulus(0, 0, 3'd0, 32'd0, 32'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!mem_req_o) break;
            reqCycles++;
            nVectors++;
            if ({err_o, stall_o} !== {reqCycles == 16, 1'b1}) begin
                nMiscompares++;
                $display("[TB] FAIL timeout_cycle%0d: got err/stall=%b want %b", reqCycles,
                         {err_o, stall_o}, {reqCycles == 16, 1'b1});
            end
            @(posedge clk); #1;
        end
        nVectors++;
        if (reqCycles != 16 || {stall_o, err_o, rvalid_o} !== 3'b000) begin
            nMiscompares++;
            $display("[TB] FAIL timeout_end: got req cycles=%0d stall/err/rv=%b want 16 000",
                     reqCycles, {stall_o, err_o, rvalid_o});
        end
        @(posedge clk); #1;
    endtask

    // Memory ack while idle has no effect
    task automatic test_ack_idle();
        mem_ack_i = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        @(negedge clk);
        nVectors++;
        if ({mem_req_o, rvalid_o, stall_o, err_o} !== 4'b0000) begin
            nMiscompares++;
            $display("[TB] FAIL ack_idle: got req/rv/stall/err=%b want 0000", {mem_req_o, rvalid_o, stall_o, err_o});
        end
        @(posedge clk); #1;
    endtask

    // Reset in the second REQ cycle drops the request immediately
    task automatic test_reset_mid();
        applyStimulus(1, 0, 3'b010, 32'h300, 32'h0);
        mem_ack_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        lastLoad = 32'd0;
        nVectors++;
        if ({mem_req_o, stall_o, err_o, rvalid_o} !== 4'b0000 || rdata_o !== 32'd0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_mid: got req/stall/err/rv=%b rdata=%h want 0000 0",
                     {mem_req_o, stall_o, err_o, rvalid_o}, rdata_o);
        end
        applyStimulus(0, 0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_access(1, 0, 3'b010, 32'h300, 32'h0, 32'h0BADF00D, 0, "lw_after_reset");
    endtask

    // Back-to-back store then load with no idle gap
    task automatic test_back_to_back();
        run_access(0, 1, 3'b010, 32'h400, 32'h11223344, 32'h0, 0, "b2b_sw");
        run_access(1, 0, 3'b000, 32'h401, 32'h0, 32'h11223344, 0, "b2b_lb");
        run_access(1, 0, 3'b001, 32'h402, 32'h0, 32'hF00F1234, 1, "b2b_lh");
    endtask

    // Random mix of legal and illegal accesses with random memory latency
    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            bit rd, wr;
            int sel;
            sel = $urandom_range(0, 9);
            rd  = (sel <= 5) || (sel == 9);
            wr  = (sel >= 6);
            run_access(rd, wr, 3'($urandom_range(0, 7)), 32'h1000 + $urandom_range(0, 63),
                       $urandom, $urandom, $urandom_range(0, 5), $sformatf("rand%0d", t));
        end
    endtask

    // Test sequence
    initial begin
        rst_n       = 1'b0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'd0;
        applyStimulus(0, 0, 3'd0, 32'd0, 32'd0);
        #3;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_loads();
        test_stores();
        test_errors();
        test_ack_at_expiry();
        test_timeout();
        test_ack_idle();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
